// File: rtl/debug_ring_fifo.sv
// Circular FIFO for the CPU debug I/O path with a clock-divider strobe,
// edge-detected request handshakes and sticky overflow/underflow flags.
module debug_ring_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned MODE  = 0,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             outclk,
  output logic             tick,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DIV_W-1:0] counter_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic             wr_q;
  logic             rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic we_ev;
  logic re_ev;
  logic do_wr;
  logic do_rd;
  logic set_ovf;
  logic set_udf;

  assign tick  = (counter_q == clkdiv);
  assign empty = (count == '0);
  assign full  = (count == FullCount);

  // In sampling mode the host request line is ignored; only non-zero words on a tick are stored.
  assign we_ev   = (MODE == 0) ? (wr_req & ~wr_q) : (tick & (|wr_data));
  assign re_ev   = rd_req & ~rd_q;
  assign do_wr   = we_ev & (~full | re_ev);
  assign do_rd   = re_ev & ~empty;
  assign set_ovf = we_ev & full & ~re_ev;
  assign set_udf = re_ev & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      outclk    <= 1'b0;
      wr_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      counter_q <= tick ? '0 : counter_q + DIV_W'(1);
      if (tick) begin
        outclk <= ~outclk;
      end
      wr_q <= wr_req;
      rd_q <= rd_req;

      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_data  <= mem_q[rd_ptr_q];
      end
      rd_valid <= do_rd;

      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase

      // A new error event takes priority over a clear in the same cycle.
      if (set_ovf) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (set_udf) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_debug_ring_fifo.sv
// Directed self-checking bench: a host-push instance (MODE 0) and a tick-sampling instance (MODE 1).
module tb_debug_ring_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // MODE 0 instance signals
  logic             rst0, wr_req0, rd_req0, clr_err0;
  logic [DIV_W-1:0] clkdiv0;
  logic [WIDTH-1:0] wr_data0, rd_data0;
  logic             outclk0, tick0, rd_valid0, empty0, full0, overflow0, underflow0;
  logic [AW:0]      count0;

  // MODE 1 instance signals
  logic             rst1, wr_req1, rd_req1, clr_err1;
  logic [DIV_W-1:0] clkdiv1;
  logic [WIDTH-1:0] wr_data1, rd_data1;
  logic             outclk1, tick1, rd_valid1, empty1, full1, overflow1, underflow1;
  logic [AW:0]      count1;

  debug_ring_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst0), .clkdiv(clkdiv0), .outclk(outclk0), .tick(tick0),
    .wr_data(wr_data0), .wr_req(wr_req0), .rd_req(rd_req0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .count(count0), .empty(empty0), .full(full0),
    .overflow(overflow0), .underflow(underflow0), .clr_err(clr_err0)
  );

  debug_ring_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst1), .clkdiv(clkdiv1), .outclk(outclk1), .tick(tick1),
    .wr_data(wr_data1), .wr_req(wr_req1), .rd_req(rd_req1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .count(count1), .empty(empty1), .full(full1),
    .overflow(overflow1), .underflow(underflow1), .clr_err(clr_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the active edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [WIDTH-1:0] d);
    wr_data0 = d;
    wr_req0  = 1'b1;
    step();
    wr_req0  = 1'b0;
    step();
  endtask

  task automatic pop0(input string tag, input logic [WIDTH-1:0] exp);
    rd_req0 = 1'b1;
    step();
    check({tag, "_valid"}, 32'(rd_valid0), 32'd1);
    check({tag, "_data"}, 32'(rd_data0), 32'(exp));
    rd_req0 = 1'b0;
    step();
  endtask

  task automatic pop1(input string tag, input logic [WIDTH-1:0] exp);
    rd_req1 = 1'b1;
    step();
    check({tag, "_valid"}, 32'(rd_valid1), 32'd1);
    check({tag, "_data"}, 32'(rd_data1), 32'(exp));
    rd_req1 = 1'b0;
    step();
  endtask

  // Bounded wait until the MODE 1 divider tick is visible.
  task automatic wait_tick1();
    int k = 0;
    while (!tick1 && k < 8) begin
      step();
      k++;
    end
    if (!tick1) check("tick1_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] samples [4];
    samples[0] = 16'h0000; samples[1] = 16'h0012;
    samples[2] = 16'h0000; samples[3] = 16'h0034;

    rst0 = 1'b1; wr_req0 = 1'b0; rd_req0 = 1'b0; clr_err0 = 1'b0;
    clkdiv0 = 16'd3; wr_data0 = '0;
    rst1 = 1'b1; wr_req1 = 1'b0; rd_req1 = 1'b0; clr_err1 = 1'b0;
    clkdiv1 = 16'd1; wr_data1 = '0;
    step(3);

    // Reset state, then divider with clkdiv = 3.
    check("rst_count", 32'(count0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_outclk", 32'(outclk0), 32'd0);
    check("rst_tick", 32'(tick0), 32'd0);
    check("rst_rd_data", 32'(rd_data0), 32'd0);
    check("rst_rd_valid", 32'(rd_valid0), 32'd0);
    check("rst_flags", {30'd0, overflow0, underflow0}, 32'd0);
    rst0 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("tick_c%0d", i), 32'(tick0), 32'((i % 4) == 3));
      check($sformatf("outclk_c%0d", i), 32'(outclk0), 32'((i / 4) % 2));
    end

    // Ordered push/pop.
    for (int i = 1; i <= 5; i++) push0(WIDTH'(i));
    check("fill5_count", 32'(count0), 32'd5);
    for (int i = 1; i <= 5; i++) pop0($sformatf("order%0d", i), WIDTH'(i));
    check("order_valid_low", 32'(rd_valid0), 32'd0);
    check("order_empty", 32'(empty0), 32'd1);

    // Fill to full, overflow, pop oldest, clear error.
    for (int i = 0; i < 32; i++) push0(WIDTH'(16'h0100 + i));
    check("fill_full", 32'(full0), 32'd1);
    check("fill_ovf_pre", 32'(overflow0), 32'd0);
    push0(16'hBEEF);
    check("ovf_set", 32'(overflow0), 32'd1);
    check("ovf_count", 32'(count0), 32'd32);
    pop0("ovf_pop", 16'h0100);
    check("ovf_pop_count", 32'(count0), 32'd31);
    clr_err0 = 1'b1;
    step();
    clr_err0 = 1'b0;
    check("clr_ovf", 32'(overflow0), 32'd0);
    for (int i = 1; i < 32; i++) pop0($sformatf("drain%0d", i), WIDTH'(16'h0100 + i));
    check("drain_empty", 32'(empty0), 32'd1);

    // Pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) push0(WIDTH'(16'h1000 * (r + 1) + i));
      check($sformatf("wrap%0d_count", r), 32'(count0), 32'd20);
      for (int i = 0; i < 20; i++) pop0($sformatf("wrap%0d_%0d", r, i), WIDTH'(16'h1000 * (r + 1) + i));
    end
    check("wrap_count_end", 32'(count0), 32'd0);

    // Full with simultaneous push and pop edges.
    for (int i = 0; i < 32; i++) push0(WIDTH'(16'h0200 + i));
    wr_data0 = 16'h03AA;
    wr_req0 = 1'b1;
    rd_req0 = 1'b1;
    step();
    check("sim_valid", 32'(rd_valid0), 32'd1);
    check("sim_data", 32'(rd_data0), 32'h0200);
    check("sim_count", 32'(count0), 32'd32);
    check("sim_ovf", 32'(overflow0), 32'd0);
    wr_req0 = 1'b0;
    rd_req0 = 1'b0;
    step();
    for (int i = 1; i < 32; i++) pop0($sformatf("sim_drain%0d", i), WIDTH'(16'h0200 + i));
    pop0("sim_new", 16'h03AA);

    // Underflow on empty pop.
    rd_req0 = 1'b1;
    step();
    check("udf_set", 32'(underflow0), 32'd1);
    check("udf_valid", 32'(rd_valid0), 32'd0);
    check("udf_data_hold", 32'(rd_data0), 32'h03AA);
    rd_req0 = 1'b0;
    clr_err0 = 1'b1;
    step();
    clr_err0 = 1'b0;
    check("udf_clr", 32'(underflow0), 32'd0);

    // Push + pop on empty: pop underflows, push lands.
    wr_data0 = 16'h0777;
    wr_req0 = 1'b1;
    rd_req0 = 1'b1;
    step();
    check("emp_sim_count", 32'(count0), 32'd1);
    check("emp_sim_udf", 32'(underflow0), 32'd1);
    check("emp_sim_valid", 32'(rd_valid0), 32'd0);
    wr_req0 = 1'b0;
    rd_req0 = 1'b0;
    step();
    pop0("emp_sim_pop", 16'h0777);

    // MODE 1: sample non-zero words on each tick.
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick1();
      wr_data1 = samples[i];
      step();
    end
    wr_data1 = '0;
    check("m1_count", 32'(count1), 32'd2);
    pop1("m1_pop0", 16'h0012);
    pop1("m1_pop1", 16'h0034);
    check("m1_empty", 32'(empty1), 32'd1);

    // Reset mid-stream with rd_req held high across it.
    wr_data1 = 16'h0055;
    step(6);
    check("m1_stream_nonzero", 32'(count1 != 0), 32'd1);
    rd_req1 = 1'b1;
    rst1 = 1'b1;
    wr_data1 = '0;
    step(2);
    rst1 = 1'b0;
    check("m1_rst_count", 32'(count1), 32'd0);
    step();
    check("m1_held_valid0", 32'(rd_valid1), 32'd0);
    step();
    check("m1_held_valid1", 32'(rd_valid1), 32'd0);
    check("m1_held_udf", 32'(underflow1), 32'd0);
    rd_req1 = 1'b0;
    step();
    rd_req1 = 1'b1;
    step();
    check("m1_new_edge_udf", 32'(underflow1), 32'd1);
    rd_req1 = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
